// File: rtl/ub_tile_sequencer_if.sv
// Read-address bus between the control FSM, ub_tile_sequencer and unified_buffer.
// The master side is the sequencer. The slave side is the job controller and buffer.
interface ub_tile_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned REP_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] cfg_input_base;
  logic [ADDR_W-1:0] cfg_input_stride;
  logic [ADDR_W-1:0] cfg_weight_base;
  logic [LEN_W-1:0]  cfg_len;
  logic [REP_W-1:0]  cfg_reps;
  logic              stall;
  logic [ADDR_W-1:0] input_addr;
  logic              input_first;
  logic              input_last;
  logic [ADDR_W-1:0] weight_addr;
  logic              weight_first;
  logic              weight_last;
  logic              rd_valid;
  logic              busy;
  logic              done;

  modport master (
    input  start, cfg_input_base, cfg_input_stride, cfg_weight_base, cfg_len, cfg_reps, stall,
    output input_addr, input_first, input_last, weight_addr, weight_first, weight_last,
           rd_valid, busy, done
  );

  modport slave (
    output start, cfg_input_base, cfg_input_stride, cfg_weight_base, cfg_len, cfg_reps, stall,
    input  input_addr, input_first, input_last, weight_addr, weight_first, weight_last,
           rd_valid, busy, done
  );
endinterface

// File: rtl/ub_tile_sequencer.sv
// Read-address sequencer for unified_buffer: walks one weight tile against cfg_reps input tiles,
// cfg_len beats per pass, with registered addresses, first/last markers and a stall freeze.
module ub_tile_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned REP_W  = 8
) (
  input logic clk,
  input logic rst_n,
  ub_tile_sequencer_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  k_q, k_d, adv_k;
  logic [REP_W-1:0]  r_q, r_d, adv_r;
  logic [ADDR_W-1:0] tile_q, tile_d, adv_tile;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [REP_W-1:0]  reps_q, reps_d;
  logic [ADDR_W-1:0] input_addr_q, input_addr_d;
  logic [ADDR_W-1:0] weight_addr_q, weight_addr_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_k, final_beat;

  // k/r/tile describe the beat whose addresses are on the outputs; rd_valid_q says it was issued.
  assign last_k     = (k_q == len_q - LEN_W'(1));
  assign final_beat = last_k && (r_q == reps_q - REP_W'(1));

  // Successor beat; the input tile base is a running sum rather than r*stride.
  always_comb begin
    adv_k    = k_q + LEN_W'(1);
    adv_r    = r_q;
    adv_tile = tile_q;
    if (last_k) begin
      adv_k    = '0;
      adv_r    = r_q + REP_W'(1);
      adv_tile = tile_q + stride_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    r_d           = r_q;
    tile_d        = tile_q;
    stride_d      = stride_q;
    wbase_d       = wbase_q;
    len_d         = len_q;
    reps_d        = reps_q;
    input_addr_d  = input_addr_q;
    weight_addr_d = weight_addr_q;
    first_d       = 1'b0;
    last_d        = 1'b0;
    rd_valid_d    = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          stride_d = bus.cfg_input_stride;
          wbase_d  = bus.cfg_weight_base;
          len_d    = bus.cfg_len;
          reps_d   = bus.cfg_reps;
          k_d      = '0;
          r_d      = '0;
          tile_d   = bus.cfg_input_base;
          busy_d   = 1'b1;
          if (bus.cfg_len != '0 && bus.cfg_reps != '0) begin
            state_d       = RUN;
            input_addr_d  = bus.cfg_input_base;
            weight_addr_d = bus.cfg_weight_base;
            rd_valid_d    = 1'b1;
            first_d       = 1'b1;
            last_d        = (bus.cfg_len == LEN_W'(1));
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (rd_valid_q && final_beat) begin
          state_d = DRAIN;
        end else begin
          // A stalled beat is shown with its addresses but not issued until stall drops.
          if (rd_valid_q) begin
            k_d    = adv_k;
            r_d    = adv_r;
            tile_d = adv_tile;
          end
          input_addr_d  = tile_d + ADDR_W'(k_d);
          weight_addr_d = wbase_q + ADDR_W'(k_d);
          if (!bus.stall) begin
            rd_valid_d = 1'b1;
            first_d    = (k_d == '0);
            last_d     = (k_d == len_q - LEN_W'(1));
          end
        end
      end
      DRAIN: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      k_q           <= '0;
      r_q           <= '0;
      tile_q        <= '0;
      stride_q      <= '0;
      wbase_q       <= '0;
      len_q         <= '0;
      reps_q        <= '0;
      input_addr_q  <= '0;
      weight_addr_q <= '0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      rd_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      r_q           <= r_d;
      tile_q        <= tile_d;
      stride_q      <= stride_d;
      wbase_q       <= wbase_d;
      len_q         <= len_d;
      reps_q        <= reps_d;
      input_addr_q  <= input_addr_d;
      weight_addr_q <= weight_addr_d;
      first_q       <= first_d;
      last_q        <= last_d;
      rd_valid_q    <= rd_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.input_addr   = input_addr_q;
  assign bus.weight_addr  = weight_addr_q;
  assign bus.input_first  = first_q;
  assign bus.weight_first = first_q;
  assign bus.input_last   = last_q;
  assign bus.weight_last  = last_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_ub_tile_sequencer.sv
// Directed bench for ub_tile_sequencer: hand-computed per-cycle address/marker/status vectors.
// Cycle n means the outputs seen 1 ns after the n-th rising edge following the start edge.
module tb_ub_tile_sequencer;
  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  ub_tile_sequencer_if #(.ADDR_W(16), .LEN_W(8), .REP_W(8)) bus ();

  ub_tile_sequencer #(.ADDR_W(16), .LEN_W(8), .REP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {input_addr, weight_addr, rd_valid, in_first, in_last, w_first, w_last, busy, done}
  function automatic logic [38:0] ev(input logic [15:0] ia, input logic [15:0] wa,
                                     input logic v, input logic f, input logic l,
                                     input logic b, input logic d);
    return {ia, wa, v, f, l, f, l, b, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [38:0] expv);
    logic [38:0] obs;
    obs = {bus.input_addr, bus.weight_addr, bus.rd_valid, bus.input_first, bus.input_last,
           bus.weight_first, bus.weight_last, bus.busy, bus.done};
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, expv);
    end
  endtask

  // {rd_valid, busy, done} only
  task automatic chk_ctl(input string tag, input logic [2:0] expv);
    logic [2:0] obs;
    obs = {bus.rd_valid, bus.busy, bus.done};
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b required %b", tag, obs, expv);
    end
  endtask

  task automatic cs(input string tag, input logic [38:0] expv);
    chk(tag, expv);
    step();
  endtask

  // Start is high only for the accepting edge; returns in cycle 1.
  task automatic go(input logic [15:0] base, input logic [15:0] stride, input logic [15:0] wbase,
                    input logic [7:0] len, input logic [7:0] reps);
    bus.cfg_input_base   = base;
    bus.cfg_input_stride = stride;
    bus.cfg_weight_base  = wbase;
    bus.cfg_len          = len;
    bus.cfg_reps         = reps;
    bus.start            = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_t1(input string tag);
    go(16'h0010, 16'h0100, 16'h0040, 8'd4, 8'd1);
    cs({tag, "_c1"}, ev(16'h0010, 16'h0040, 1, 1, 0, 1, 0));
    cs({tag, "_c2"}, ev(16'h0011, 16'h0041, 1, 0, 0, 1, 0));
    cs({tag, "_c3"}, ev(16'h0012, 16'h0042, 1, 0, 0, 1, 0));
    cs({tag, "_c4"}, ev(16'h0013, 16'h0043, 1, 0, 1, 1, 0));
    cs({tag, "_c5_drain"}, ev(16'h0013, 16'h0043, 0, 0, 0, 1, 0));
    cs({tag, "_c6_done"}, ev(16'h0013, 16'h0043, 0, 0, 0, 1, 1));
    cs({tag, "_c7_idle"}, ev(16'h0013, 16'h0043, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.start            = 1'b0;
    bus.stall            = 1'b0;
    bus.cfg_input_base   = '0;
    bus.cfg_input_stride = '0;
    bus.cfg_weight_base  = '0;
    bus.cfg_len          = '0;
    bus.cfg_reps         = '0;
    #1;
    chk("reset", ev(16'h0, 16'h0, 0, 0, 0, 0, 0));
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", ev(16'h0, 16'h0, 0, 0, 0, 0, 0));

    // T1: single pass of four beats
    run_t1("t1");

    // T2: two passes, each with its own first/last
    go(16'h0000, 16'h0020, 16'h0080, 8'd3, 8'd2);
    cs("t2_c1", ev(16'h0000, 16'h0080, 1, 1, 0, 1, 0));
    cs("t2_c2", ev(16'h0001, 16'h0081, 1, 0, 0, 1, 0));
    cs("t2_c3", ev(16'h0002, 16'h0082, 1, 0, 1, 1, 0));
    cs("t2_c4", ev(16'h0020, 16'h0080, 1, 1, 0, 1, 0));
    cs("t2_c5", ev(16'h0021, 16'h0081, 1, 0, 0, 1, 0));
    cs("t2_c6", ev(16'h0022, 16'h0082, 1, 0, 1, 1, 0));
    cs("t2_c7_drain", ev(16'h0022, 16'h0082, 0, 0, 0, 1, 0));
    cs("t2_c8_done", ev(16'h0022, 16'h0082, 0, 0, 0, 1, 1));
    cs("t2_c9_idle", ev(16'h0022, 16'h0082, 0, 0, 0, 0, 0));

    // T3: stall sampled on the two edges that would issue beats 1 and 2
    go(16'h0010, 16'h0100, 16'h0040, 8'd4, 8'd1);
    bus.stall = 1'b1;
    cs("t3_c1", ev(16'h0010, 16'h0040, 1, 1, 0, 1, 0));
    cs("t3_c2_stall", ev(16'h0011, 16'h0041, 0, 0, 0, 1, 0));
    bus.stall = 1'b0;
    cs("t3_c3_stall", ev(16'h0011, 16'h0041, 0, 0, 0, 1, 0));
    cs("t3_c4_replay", ev(16'h0011, 16'h0041, 1, 0, 0, 1, 0));
    cs("t3_c5", ev(16'h0012, 16'h0042, 1, 0, 0, 1, 0));
    cs("t3_c6", ev(16'h0013, 16'h0043, 1, 0, 1, 1, 0));
    cs("t3_c7_drain", ev(16'h0013, 16'h0043, 0, 0, 0, 1, 0));
    cs("t3_c8_done", ev(16'h0013, 16'h0043, 0, 0, 0, 1, 1));
    cs("t3_c9_idle", ev(16'h0013, 16'h0043, 0, 0, 0, 0, 0));

    // T4: empty jobs go straight to DONE
    go(16'h0100, 16'h0010, 16'h0200, 8'd0, 8'd3);
    chk_ctl("t4a_len0_done", 3'b011);
    step();
    chk_ctl("t4a_len0_idle", 3'b000);
    go(16'h0100, 16'h0010, 16'h0200, 8'd5, 8'd0);
    chk_ctl("t4b_reps0_done", 3'b011);
    step();
    chk_ctl("t4b_reps0_idle", 3'b000);
    step();

    // T5: asynchronous reset while beat 2 is on the outputs
    go(16'h0010, 16'h0100, 16'h0040, 8'd4, 8'd1);
    cs("t5_c1", ev(16'h0010, 16'h0040, 1, 1, 0, 1, 0));
    cs("t5_c2", ev(16'h0011, 16'h0041, 1, 0, 0, 1, 0));
    chk("t5_c3", ev(16'h0012, 16'h0042, 1, 0, 0, 1, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_clear", ev(16'h0, 16'h0, 0, 0, 0, 0, 0));
    step();
    chk("t5_held_reset", ev(16'h0, 16'h0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step();
    chk("t5_no_done", ev(16'h0, 16'h0, 0, 0, 0, 0, 0));
    step();
    chk("t5_still_idle", ev(16'h0, 16'h0, 0, 0, 0, 0, 0));
    run_t1("t5_rerun");

    // T6: address wrap; a second start with new config mid-job is ignored
    go(16'hFFFE, 16'h0010, 16'hFFFF, 8'd4, 8'd1);
    chk("t6_c1", ev(16'hFFFE, 16'hFFFF, 1, 1, 0, 1, 0));
    bus.cfg_input_base  = 16'h0500;
    bus.cfg_weight_base = 16'h0600;
    bus.cfg_len         = 8'd2;
    bus.cfg_reps        = 8'd1;
    bus.start           = 1'b1;
    step();
    cs("t6_c2", ev(16'hFFFF, 16'h0000, 1, 0, 0, 1, 0));
    bus.start = 1'b0;
    cs("t6_c3", ev(16'h0000, 16'h0001, 1, 0, 0, 1, 0));
    cs("t6_c4", ev(16'h0001, 16'h0002, 1, 0, 1, 1, 0));
    cs("t6_c5_drain", ev(16'h0001, 16'h0002, 0, 0, 0, 1, 0));
    cs("t6_c6_done", ev(16'h0001, 16'h0002, 0, 0, 0, 1, 1));
    cs("t6_c7_idle", ev(16'h0001, 16'h0002, 0, 0, 0, 0, 0));
    chk("t6_c8_no_second_job", ev(16'h0001, 16'h0002, 0, 0, 0, 0, 0));

    // T7: len=1 (first=last every beat), stride wrap, restart only once back in IDLE
    go(16'hFFF0, 16'h0008, 16'h0020, 8'd1, 8'd3);
    cs("t7_c1", ev(16'hFFF0, 16'h0020, 1, 1, 1, 1, 0));
    cs("t7_c2", ev(16'hFFF8, 16'h0020, 1, 1, 1, 1, 0));
    cs("t7_c3", ev(16'h0000, 16'h0020, 1, 1, 1, 1, 0));
    cs("t7_c4_drain", ev(16'h0000, 16'h0020, 0, 0, 0, 1, 0));
    chk("t7_c5_done", ev(16'h0000, 16'h0020, 0, 0, 0, 1, 1));
    bus.cfg_len  = 8'd0;
    bus.cfg_reps = 8'd0;
    bus.start    = 1'b1;
    step();
    chk("t7_c6_start_in_done_ignored", ev(16'h0000, 16'h0020, 0, 0, 0, 0, 0));
    step();
    chk_ctl("t7_c7_restart_accepted", 3'b011);
    bus.start = 1'b0;
    step();
    chk_ctl("t7_c8_idle", 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
